// File: rtl/mem_arbiter.sv
// Two-master arbiter for the shared single-port memory: round-robin grant with a
// bounded ownership lock, registered memory command and fixed-latency read return.
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int LOCK_MAX   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic                  m0_lock,
    input  logic [DATA_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,

    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic                  m1_lock,
    input  logic [DATA_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,

    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t                state;
    logic                  last_grant;
    logic [3:0]            lock_cnt;
    logic [3:0]            cnt_inc;
    logic                  tag_valid;
    logic                  tag_id;

    logic                  acc;
    logic                  acc_id;
    logic                  acc_we;
    logic                  acc_lock;
    logic [DATA_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] acc_wdata;

    // NOTE: every output of this block gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch on the grants.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        // Grants are gated by reset so nothing is accepted while the block is held.
        if (rst_n) begin
            unique case (state)
                IDLE: begin
                    if (m0_req && m1_req) begin
                        m0_gnt = last_grant;
                        m1_gnt = !last_grant;
                    end else begin
                        m0_gnt = m0_req;
                        m1_gnt = m1_req;
                    end
                end
                OWN0:    m0_gnt = m0_req;
                OWN1:    m1_gnt = m1_req;
                default: ;
            endcase
        end
    end

    assign acc       = (m0_req && m0_gnt) || (m1_req && m1_gnt);
    assign acc_id    = m1_req && m1_gnt;
    assign acc_we    = acc_id ? m1_we    : m0_we;
    assign acc_lock  = acc_id ? m1_lock  : m0_lock;
    assign acc_addr  = acc_id ? m1_addr  : m0_addr;
    assign acc_wdata = acc_id ? m1_wdata : m0_wdata;
    assign cnt_inc   = lock_cnt + 4'd1;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            lock_cnt   <= 4'd0;
        end else begin
            if (acc) begin
                last_grant <= acc_id;
            end
            unique case (state)
                IDLE: begin
                    if (acc && acc_lock) begin
                        state    <= acc_id ? OWN1 : OWN0;
                        lock_cnt <= 4'd1;
                    end
                end
                OWN0, OWN1: begin
                    // Only the owner can be accepted here; reaching LOCK_MAX forces release.
                    if (acc && acc_lock && (cnt_inc != 4'(LOCK_MAX))) begin
                        lock_cnt <= cnt_inc;
                    end else begin
                        state    <= IDLE;
                        lock_cnt <= 4'd0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    lock_cnt <= 4'd0;
                end
            endcase
        end
    end

    // Memory command and pending-read tag; address and data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            tag_valid <= 1'b0;
            tag_id    <= 1'b0;
        end else begin
            mem_we    <= acc && acc_we;
            mem_re    <= acc && !acc_we;
            tag_valid <= acc && !acc_we;
            if (acc) begin
                mem_addr  <= acc_addr;
                mem_wdata <= acc_wdata;
                tag_id    <= acc_id;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            m0_rvalid <= tag_valid && !tag_id;
            m1_rvalid <= tag_valid && tag_id;
            if (tag_valid && !tag_id) begin
                m0_rdata <= mem_rdata;
            end
            if (tag_valid && tag_id) begin
                m1_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus held-request random traffic,
// checked cycle by cycle against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

    localparam int DW       = 32;
    localparam int LOCK_MAX = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
    logic [DW-1:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
    logic          mem_we, mem_re;

    mem_arbiter #(.DATA_WIDTH(DW), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port memory: combinational read, write on the clock edge.
    logic [DW-1:0] mem [0:255];
    logic          mem_clear = 1'b1;
    assign mem_rdata = mem[mem_addr[7:0]];
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (mem_we) begin
            mem[mem_addr[7:0]] <= mem_wdata;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: owner (-1 none), beats taken under lock, last winner,
    // shadow memory updated at acceptance, and the read due at the next edge.
    int            owner = -1;
    int            beats = 0;
    int            last  = 1;
    int            wait0 = 0;
    int            wait1 = 0;
    logic [DW-1:0] shadow [0:255];
    logic          pend_v = 1'b0;
    logic          pend_id = 1'b0;
    logic [DW-1:0] pend_data = '0;
    logic [DW-1:0] exp_rd0 = '0, exp_rd1 = '0, exp_maddr = '0, exp_mwdata = '0;
    logic          macc0, macc1;

    task automatic model_reset();
        owner = -1; beats = 0; last = 1; wait0 = 0; wait1 = 0;
        pend_v = 1'b0; exp_rd0 = '0; exp_rd1 = '0; exp_maddr = '0; exp_mwdata = '0;
    endtask

    // One cycle: drive at posedge+1, check grants, advance across the edge, check outputs.
    task automatic step(input logic r0, w0, k0, input logic [DW-1:0] a0, d0,
                        input logic r1, w1, k1, input logic [DW-1:0] a1, d1);
        logic g0, g1, we, lk, ev0, ev1, xm;
        logic [DW-1:0] a, d;
        m0_req = r0; m0_we = w0; m0_lock = k0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_lock = k1; m1_addr = a1; m1_wdata = d1;
        #1;
        g0 = 1'b0; g1 = 1'b0;
        if (owner == 0)      g0 = r0;
        else if (owner == 1) g1 = r1;
        else if (r0 && r1) begin g0 = (last == 1); g1 = (last == 0); end
        else begin g0 = r0; g1 = r1; end
        check("m0_gnt", 32'(m0_gnt), 32'(g0));
        check("m1_gnt", 32'(m1_gnt), 32'(g1));
        macc0 = r0 && g0;
        macc1 = r1 && g1;
        @(posedge clk);
        ev0 = pend_v && !pend_id;
        ev1 = pend_v && pend_id;
        if (ev0) exp_rd0 = pend_data;
        if (ev1) exp_rd1 = pend_data;
        pend_v = 1'b0;
        we = 1'b0;
        if (macc0 || macc1) begin
            xm = macc1;
            we = xm ? w1 : w0;
            lk = xm ? k1 : k0;
            a  = xm ? a1 : a0;
            d  = xm ? d1 : d0;
            exp_maddr = a; exp_mwdata = d;
            if (we) shadow[a[7:0]] = d;
            else begin pend_v = 1'b1; pend_id = xm; pend_data = shadow[a[7:0]]; end
            if (!xm) begin
                check("m0_wait_bound", (wait0 <= LOCK_MAX + 1) ? 32'd1 : 32'd0, 32'd1);
                wait0 = 0;
                if (r1) wait1++;
            end else begin
                check("m1_wait_bound", (wait1 <= LOCK_MAX + 1) ? 32'd1 : 32'd0, 32'd1);
                wait1 = 0;
                if (r0) wait0++;
            end
            if (owner < 0) begin
                if (lk) begin owner = xm ? 1 : 0; beats = 1; end
            end else begin
                beats++;
                if (!lk || beats == LOCK_MAX) begin owner = -1; beats = 0; end
            end
            last = xm ? 1 : 0;
        end else begin
            owner = -1; beats = 0;
        end
        #1;
        check("m0_rvalid", 32'(m0_rvalid), 32'(ev0));
        check("m1_rvalid", 32'(m1_rvalid), 32'(ev1));
        check("m0_rdata", m0_rdata, exp_rd0);
        check("m1_rdata", m1_rdata, exp_rd1);
        check("mem_we", 32'(mem_we), 32'((macc0 || macc1) && we));
        check("mem_re", 32'(mem_re), 32'((macc0 || macc1) && !we));
        check("mem_addr", mem_addr, exp_maddr);
        check("mem_wdata", mem_wdata, exp_mwdata);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_m0_gnt"}, 32'(m0_gnt), 32'd0);
        check({tag, "_m1_gnt"}, 32'(m1_gnt), 32'd0);
        check({tag, "_m0_rvalid"}, 32'(m0_rvalid), 32'd0);
        check({tag, "_m1_rvalid"}, 32'(m1_rvalid), 32'd0);
        check({tag, "_m0_rdata"}, m0_rdata, '0);
        check({tag, "_m1_rdata"}, m1_rdata, '0);
        check({tag, "_mem_addr"}, mem_addr, '0);
        check({tag, "_mem_wdata"}, mem_wdata, '0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_re"}, 32'(mem_re), 32'd0);
    endtask

    logic          r0, w0, k0, r1, w1, k1;
    logic [DW-1:0] a0, d0, a1, d1;

    initial begin
        m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;
        for (int i = 0; i < 256; i++) shadow[i] = '0;
        model_reset();

        // Reset state, with both masters requesting to show grants are held off.
        m0_req = 1; m1_req = 1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        m0_req = 0; m1_req = 0; mem_clear = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single read after a write.
        step(1, 1, 0, 32'h10, 32'hA5, 0, 0, 0, '0, '0);
        step(1, 0, 0, 32'h10, '0,     0, 0, 0, '0, '0);
        step(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        check("single_rvalid", 32'(m0_rvalid), 32'd1);
        check("single_rdata", m0_rdata, 32'hA5);
        idle(2);

        // Contention: continuous reads from both masters alternate.
        step(1, 1, 0, 32'h20, 32'h111, 0, 0, 0, '0, '0);
        step(0, 0, 0, '0, '0, 1, 1, 0, 32'h21, 32'h222);
        for (int i = 0; i < 8; i++) step(1, 0, 0, 32'h20, '0, 1, 0, 0, 32'h21, '0);
        idle(3);

        // m1 locked reads against continuous m0 requests: forced release after LOCK_MAX.
        for (int i = 0; i < 10; i++) step(1, 0, 0, 32'h20, '0, 1, 0, 1, 32'h21, '0);
        idle(3);

        // Early release on the second locked beat; waiting m1 follows.
        step(1, 0, 1, 32'h10, '0, 0, 0, 0, '0, '0);
        step(1, 0, 0, 32'h20, '0, 1, 0, 0, 32'h21, '0);
        step(0, 0, 0, '0, '0, 1, 0, 0, 32'h21, '0);
        check("early_release_m1_rvalid_gap", 32'(m1_rvalid), 32'd0);
        idle(3);

        // Back-to-back read-after-write.
        step(1, 1, 0, 32'h3, 32'h1234, 0, 0, 0, '0, '0);
        step(1, 0, 0, 32'h3, '0,       0, 0, 0, '0, '0);
        step(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        check("raw_rdata", m0_rdata, 32'h1234);
        idle(2);

        // Randomised traffic; a request holds its fields until accepted.
        r0 = 0; r1 = 0; w0 = 0; w1 = 0; k0 = 0; k1 = 0;
        a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        for (int i = 0; i < 2000; i++) begin
            if (!r0 || macc0) begin
                r0 = ($urandom_range(0, 3) != 0); w0 = 1'($urandom_range(0, 1));
                k0 = 1'($urandom_range(0, 1)); a0 = $urandom_range(0, 15); d0 = $urandom;
            end
            if (!r1 || macc1) begin
                r1 = ($urandom_range(0, 3) != 0); w1 = 1'($urandom_range(0, 1));
                k1 = 1'($urandom_range(0, 1)); a1 = $urandom_range(0, 15); d1 = $urandom;
            end
            step(r0, w0, k0, a0, d0, r1, w1, k1, a1, d1);
        end
        idle(3);

        // Reset one cycle after a read acceptance.
        step(1, 0, 0, 32'h5, '0, 0, 0, 0, '0, '0);
        m0_req = 1; m1_req = 1;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("midrst_hold");
        m0_req = 0; m1_req = 0;
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
        step(1, 0, 0, 32'h5, '0, 1, 0, 0, 32'h6, '0);
        check("post_rst_first_mem_addr", mem_addr, 32'h5);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 32'h5, '0, 1, 0, 0, 32'h6, '0);
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
